multicycle_controller: RTL and testbench

//  Sequencing FSM for the multi-cycle MIPS core. Shares one memory port between

---
 rtl/multicycle_controller_pkg.sv | 47 ++++
 rtl/multicycle_controller_decode.sv | 76 +++++++
 rtl/multicycle_controller.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, instruction
// classes, opcode/funct values, ALUControl codes and datapath select values.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_FAULT    = 4'd13
    } state_e;

    typedef enum logic [2:0] {
        CLS_MEM, CLS_RTYPE, CLS_JR, CLS_BRANCH, CLS_JUMP, CLS_IMM, CLS_ILLEGAL
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08, FN_JALR = 6'h09;

    localparam logic [3:0] ALUOP_ADD  = 4'd0, ALUOP_SUB = 4'd1, ALUOP_RTYPE = 4'd2;
    localparam logic [3:0] ALUOP_AND  = 4'd3, ALUOP_OR  = 4'd4, ALUOP_SLT   = 4'd5;
    localparam logic [3:0] ALUOP_SLTU = 4'd6, ALUOP_LUI = 4'd7;

    localparam logic [1:0] PCSRC_ALU  = 2'b00, PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10, PCSRC_RS     = 2'b11;
    localparam logic [1:0] REGDST_RT  = 2'b00, REGDST_RD = 2'b01, REGDST_RA = 2'b10;
    localparam logic [1:0] M2R_ALUOUT = 2'b00, M2R_MDR   = 2'b01, M2R_PC    = 2'b10;
    localparam logic [1:0] SRCA_PC    = 2'b00, SRCA_RS   = 2'b01, SRCA_SHAMT = 2'b10;
    localparam logic [1:0] SRCB_RT    = 2'b00, SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10, SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/multicycle_controller_decode.sv
// Combinational instruction decode: classifies opcode/funct and supplies the
// per-instruction ALU/extend controls used by the sequencing FSM.
module multicycle_controller_decode
    import multicycle_controller_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_e cls,
    output logic         is_load,
    output logic         is_bne,
    output logic         is_link,
    output logic         is_shift,
    output logic [3:0]   imm_alu_op,
    output logic         imm_ext_op,
    output logic         imm_lu_op
);

    always_comb begin
        cls        = CLS_ILLEGAL;
        is_load    = 1'b0;
        is_bne     = 1'b0;
        is_link    = 1'b0;
        imm_alu_op = ALUOP_ADD;
        imm_ext_op = 1'b1;
        imm_lu_op  = 1'b0;
        is_shift   = (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_JR || funct == FN_JALR) cls = CLS_JR;
                else                                    cls = CLS_RTYPE;
                is_link = (funct == FN_JALR);
            end
            OP_LW: begin
                cls     = CLS_MEM;
                is_load = 1'b1;
            end
            OP_SW:  cls = CLS_MEM;
            OP_BEQ: cls = CLS_BRANCH;
            OP_BNE: begin
                cls    = CLS_BRANCH;
                is_bne = 1'b1;
            end
            OP_J:   cls = CLS_JUMP;
            OP_JAL: begin
                cls     = CLS_JUMP;
                is_link = 1'b1;
            end
            OP_ADDI, OP_ADDIU: cls = CLS_IMM;
            OP_SLTI: begin
                cls        = CLS_IMM;
                imm_alu_op = ALUOP_SLT;
            end
            OP_SLTIU: begin
                cls        = CLS_IMM;
                imm_alu_op = ALUOP_SLTU;
            end
            OP_ANDI: begin
                cls        = CLS_IMM;
                imm_alu_op = ALUOP_AND;
                imm_ext_op = 1'b0;
            end
            OP_ORI: begin
                cls        = CLS_IMM;
                imm_alu_op = ALUOP_OR;
                imm_ext_op = 1'b0;
            end
            OP_LUI: begin
                cls        = CLS_IMM;
                imm_alu_op = ALUOP_LUI;
                imm_lu_op  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle MIPS core with mem_ready stall handling,
// memory-timeout watchdog and sticky fault state.
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE     | branch target into ALUOut, dispatch on instruction class
// MEM_ADDR   | effective address rs+imm
// MEM_RD     | data read at ALUOut, wait for mem_ready
// MEM_WB     | rt <= MDR
// MEM_WR     | data write at ALUOut, wait for mem_ready
// R_EXEC     | R-type ALU operation
// R_WB       | rd <= ALUOut
// I_EXEC     | immediate ALU operation
// I_WB       | rt <= ALUOut
// BRANCH     | compare rs/rt, conditionally load branch target
// JUMP       | j/jal
// JR         | jr/jalr
// FAULT      | illegal opcode or memory timeout; left only by reset
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int WAIT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       ext_op,
    output logic       lu_op,
    output logic       fault,
    output logic [3:0] state
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              stalled;

    instr_class_e cls;
    logic         is_load, is_bne, is_link, is_shift;
    logic [3:0]   imm_alu_op;
    logic         imm_ext_op, imm_lu_op;

    multicycle_controller_decode u_decode (
        .opcode     (opcode),
        .funct      (funct),
        .cls        (cls),
        .is_load    (is_load),
        .is_bne     (is_bne),
        .is_link    (is_link),
        .is_shift   (is_shift),
        .imm_alu_op (imm_alu_op),
        .imm_ext_op (imm_ext_op),
        .imm_lu_op  (imm_lu_op)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        stalled    = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE; else stalled = 1'b1;
            S_DECODE: begin
                case (cls)
                    CLS_MEM:    state_d = S_MEM_ADDR;
                    CLS_RTYPE:  state_d = S_R_EXEC;
                    CLS_JR:     state_d = S_JR;
                    CLS_BRANCH: state_d = S_BRANCH;
                    CLS_JUMP:   state_d = S_JUMP;
                    CLS_IMM:    state_d = S_I_EXEC;
                    default:    state_d = S_FAULT;
                endcase
            end
            S_MEM_ADDR: state_d = is_load ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB; else stalled = 1'b1;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;  else stalled = 1'b1;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FAULT;
        endcase
        // Counter only advances while the state holds, so any transition clears it.
        if (stalled) begin
            if (WAIT_LIMIT != 0 && wait_cnt_q == WAIT_LAST) state_d = S_FAULT;
            else wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Outputs are gated by reset directly so strobes drop the moment reset rises.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PCSRC_ALU;
        reg_write  = 1'b0;
        reg_dst    = REGDST_RT;
        mem_to_reg = M2R_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RT;
        alu_op     = ALUOP_ADD;
        ext_op     = 1'b0;
        lu_op      = 1'b0;
        fault      = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_a = SRCA_PC;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALUOP_ADD;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_en    = 1'b1;
                        pc_src   = PCSRC_ALU;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH2;
                    ext_op    = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = SRCA_RS;
                    alu_src_b = SRCB_IMM;
                    ext_op    = 1'b1;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = REGDST_RT;
                    mem_to_reg = M2R_MDR;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = is_shift ? SRCA_SHAMT : SRCA_RS;
                    alu_src_b = SRCB_RT;
                    alu_op    = ALUOP_RTYPE;
                end
                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = REGDST_RD;
                    mem_to_reg = M2R_ALUOUT;
                end
                S_I_EXEC: begin
                    alu_src_a = SRCA_RS;
                    alu_src_b = SRCB_IMM;
                    alu_op    = imm_alu_op;
                    ext_op    = imm_ext_op;
                    lu_op     = imm_lu_op;
                end
                S_I_WB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a = SRCA_RS;
                    alu_src_b = SRCB_RT;
                    alu_op    = ALUOP_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_en     = is_bne ? ~zero : zero;
                end
                S_JUMP: begin
                    pc_en  = 1'b1;
                    pc_src = PCSRC_JUMP;
                    if (is_link) begin
                        reg_write  = 1'b1;
                        reg_dst    = REGDST_RA;
                        mem_to_reg = M2R_PC;
                    end
                end
                S_JR: begin
                    pc_en  = 1'b1;
                    pc_src = PCSRC_RS;
                    if (is_link) begin
                        reg_write  = 1'b1;
                        reg_dst    = REGDST_RD;
                        mem_to_reg = M2R_PC;
                    end
                end
                S_FAULT: fault = 1'b1;
                default: fault = 1'b1;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: each instruction is expanded into the cycle sequence of
// control words the controller should produce, then replayed against the DUT.
module tb_multicycle_controller;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] ST_MEM_RD = 4'd3, ST_MEM_WB = 4'd4, ST_MEM_WR = 4'd5;
    localparam logic [3:0] ST_R_EXEC = 4'd6, ST_R_WB = 4'd7, ST_I_EXEC = 4'd8;
    localparam logic [3:0] ST_I_WB = 4'd9, ST_BRANCH = 4'd10, ST_JUMP = 4'd11;
    localparam logic [3:0] ST_JR = 4'd12, ST_FAULT = 4'd13;
    localparam int LIMIT = 16;

    typedef struct packed {
        logic [3:0] st;
        logic       flt, mrd, mwr, iod, irw, pce;
        logic [1:0] pcs;
        logic       rw;
        logic [1:0] rd, m2r, sa, sb;
        logic [3:0] aop;
        logic       ext, lu;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h0, funct = 6'h0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_en, reg_write;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_a, alu_src_b;
    logic [3:0] alu_op, state;
    logic       ext_op, lu_op, fault;
    obs_t       act;

    obs_t exp_q[$];
    bit   rdy_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.WAIT_LIMIT(16), .WAIT_W(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .ext_op(ext_op), .lu_op(lu_op), .fault(fault), .state(state)
    );

    assign act = {state, fault, mem_read, mem_write, i_or_d, ir_write, pc_en, pc_src,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op, lu_op};

    function automatic obs_t blank(input logic [3:0] s);
        obs_t o = '0;
        o.st = s;
        return o;
    endfunction

    function automatic void push(input obs_t o, input bit r);
        exp_q.push_back(o);
        rdy_q.push_back(r);
    endfunction

    function automatic bit rnd_bit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic void gen_fault();
        obs_t o = blank(ST_FAULT);
        o.flt = 1'b1;
        for (int k = 0; k < 4; k++) push(o, rnd_bit());
    endfunction

    // Stalls of LIMIT or more cycles end in FAULT instead of completing.
    function automatic bit gen_wait(input obs_t o, input int waits);
        if (waits >= LIMIT) begin
            for (int k = 0; k < LIMIT; k++) push(o, 1'b0);
            gen_fault();
            return 1'b1;
        end
        for (int k = 0; k < waits; k++) push(o, 1'b0);
        return 1'b0;
    endfunction

    function automatic void gen_instr(input logic [5:0] op, input logic [5:0] fn,
                                      input logic z, input int fw, input int mw);
        obs_t o;
        o = blank(ST_FETCH);
        o.mrd = 1'b1; o.sb = 2'b01;
        if (gen_wait(o, fw)) return;
        o.irw = 1'b1; o.pce = 1'b1;
        push(o, 1'b1);
        o = blank(ST_DECODE);
        o.sb = 2'b11; o.ext = 1'b1;
        push(o, rnd_bit());
        case (op)
            6'h23, 6'h2B: begin
                o = blank(ST_MEM_ADDR);
                o.sa = 2'b01; o.sb = 2'b10; o.ext = 1'b1;
                push(o, rnd_bit());
                o = blank(op == 6'h23 ? ST_MEM_RD : ST_MEM_WR);
                o.iod = 1'b1;
                if (op == 6'h23) o.mrd = 1'b1; else o.mwr = 1'b1;
                if (gen_wait(o, mw)) return;
                push(o, 1'b1);
                if (op == 6'h23) begin
                    o = blank(ST_MEM_WB);
                    o.rw = 1'b1; o.m2r = 2'b01;
                    push(o, rnd_bit());
                end
            end
            6'h00: begin
                if (fn == 6'h08 || fn == 6'h09) begin
                    o = blank(ST_JR);
                    o.pce = 1'b1; o.pcs = 2'b11;
                    if (fn == 6'h09) begin o.rw = 1'b1; o.rd = 2'b01; o.m2r = 2'b10; end
                    push(o, rnd_bit());
                end else begin
                    o = blank(ST_R_EXEC);
                    o.sa = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'b10 : 2'b01;
                    o.aop = 4'd2;
                    push(o, rnd_bit());
                    o = blank(ST_R_WB);
                    o.rw = 1'b1; o.rd = 2'b01;
                    push(o, rnd_bit());
                end
            end
            6'h04, 6'h05: begin
                o = blank(ST_BRANCH);
                o.sa = 2'b01; o.aop = 4'd1; o.pcs = 2'b01;
                o.pce = (op == 6'h04) ? z : ~z;
                push(o, rnd_bit());
            end
            6'h02, 6'h03: begin
                o = blank(ST_JUMP);
                o.pce = 1'b1; o.pcs = 2'b10;
                if (op == 6'h03) begin o.rw = 1'b1; o.rd = 2'b10; o.m2r = 2'b10; end
                push(o, rnd_bit());
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F: begin
                o = blank(ST_I_EXEC);
                o.sa = 2'b01; o.sb = 2'b10;
                case (op)
                    6'h0A:   o.aop = 4'd5;
                    6'h0B:   o.aop = 4'd6;
                    6'h0C:   o.aop = 4'd3;
                    6'h0D:   o.aop = 4'd4;
                    6'h0F:   o.aop = 4'd7;
                    default: o.aop = 4'd0;
                endcase
                o.ext = (op == 6'h0C || op == 6'h0D) ? 1'b0 : 1'b1;
                o.lu  = (op == 6'h0F);
                push(o, rnd_bit());
                o = blank(ST_I_WB);
                o.rw = 1'b1;
                push(o, rnd_bit());
            end
            default: gen_fault();
        endcase
    endfunction

    // Replays up to n queued cycles (all when n < 0); instruction bits change
    // at the start of the instruction's first fetch cycle.
    task automatic run_q(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int n);
        int i = 0;
        while (exp_q.size() > 0 && (n < 0 || i < n)) begin
            obs_t e;
            bit   r;
            e = exp_q.pop_front();
            r = rdy_q.pop_front();
            @(negedge clk);
            if (i == 0) begin opcode = op; funct = fn; zero = z; end
            mem_ready = r;
            #1;
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s step %0d: got %h expected %h", tag, i, act, e);
            end
            i++;
        end
    endtask

    task automatic exec(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int fw, input int mw);
        gen_instr(op, fn, z, fw, mw);
        run_q(tag, op, fn, z, -1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = rnd_bit();
        #1;
        n_checks++;
        if (act !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", act, obs_t'('0));
        end
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
    endtask

    task automatic test_rtype();
        exec("add", 6'h00, 6'h20, 1'b0, 0, 0);
        exec("sll", 6'h00, 6'h00, 1'b0, 0, 0);
    endtask

    task automatic test_lw_stall();
        exec("lw_stall", 6'h23, 6'h00, 1'b0, 0, 3);
        exec("sw_stall", 6'h2B, 6'h00, 1'b0, 2, 2);
    endtask

    task automatic test_branch();
        exec("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0);
        exec("bne_zero", 6'h05, 6'h00, 1'b1, 0, 0);
        exec("bne_taken", 6'h05, 6'h00, 1'b0, 0, 0);
    endtask

    task automatic test_jumps();
        exec("jal", 6'h03, 6'h00, 1'b0, 0, 0);
        exec("jalr", 6'h00, 6'h09, 1'b0, 0, 0);
        exec("j", 6'h02, 6'h00, 1'b0, 1, 0);
        exec("jr", 6'h00, 6'h08, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[15] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23};
        logic [5:0] fns[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h03,
                                6'h08, 6'h09};
        for (int k = 0; k < 50; k++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 14)];
            if (op == 6'h23 && rnd_bit()) op = 6'h2B;
            fn = fns[$urandom_range(0, 9)];
            exec("random", op, fn, rnd_bit(), $urandom_range(0, 5), $urandom_range(0, 5));
        end
    endtask

    task automatic test_illegal();
        do_reset();
        exec("illegal_3f", 6'h3F, 6'h00, 1'b0, 0, 0);
        do_reset();
        exec("after_fault", 6'h0D, 6'h00, 1'b0, 0, 0);
    endtask

    task automatic test_timeout();
        do_reset();
        exec("fetch_timeout", 6'h00, 6'h20, 1'b0, LIMIT, 0);
        do_reset();
        exec("fetch_last_ready", 6'h00, 6'h20, 1'b0, LIMIT - 1, 0);
        exec("rd_last_ready", 6'h23, 6'h00, 1'b0, 0, LIMIT - 1);
        exec("rd_timeout", 6'h23, 6'h00, 1'b0, 0, LIMIT);
        do_reset();
        exec("wr_timeout", 6'h2B, 6'h00, 1'b0, 0, LIMIT);
        do_reset();
    endtask

    task automatic test_reset_mid_write();
        obs_t o;
        gen_instr(6'h2B, 6'h00, 1'b0, 0, 10);
        run_q("sw_before_reset", 6'h2B, 6'h00, 1'b0, 5);
        exp_q.delete();
        rdy_q.delete();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (mem_write !== 1'b0 || act !== '0) begin
            n_fail++;
            $display("FAIL mid_write_reset: mem_write=%b word %h expected 0", mem_write, act);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        o = blank(ST_FETCH);
        o.mrd = 1'b1; o.sb = 2'b01;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (act !== o) begin
            n_fail++;
            $display("FAIL restart_fetch: got %h expected %h", act, o);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch();
        test_jumps();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
